// File: rtl/cnt_ovr_pkg.sv
// Shared types for the x/y counter override arbiter: override ops, FSM states, target codes.
package cnt_ovr_pkg;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'b00,
    OP_CLEAR = 2'b01,
    OP_LOAD  = 2'b10,
    OP_RSVD  = 2'b11
  } ovr_op_t;

  typedef enum logic [1:0] {
    S_IDLE   = 2'b00,
    S_ACTIVE = 2'b01,
    S_DONE   = 2'b10
  } state_t;

  localparam logic TGT_X = 1'b0;
  localparam logic TGT_Y = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping around.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] pick,
  output logic [PW-1:0]   pick_idx,
  output logic            any
);

  int cand;

  always_comb begin
    pick     = '0;
    pick_idx = '0;
    any      = 1'b0;
    cand     = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any && req[cand]) begin
        any        = 1'b1;
        pick[cand] = 1'b1;
        pick_idx   = PW'(cand);
      end
    end
  end

endmodule

// File: rtl/cnt_override_arbiter.sv
// Grants timed hold/clear/load overrides of the x/y counters one at a time, round-robin.
// All outputs are registered; with no grant both counters free-run.
module cnt_override_arbiter
  import cnt_ovr_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int W     = 4,
  parameter int DUR_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ-1:0]    req_tgt,
  input  logic [2*NREQ-1:0]  req_op,
  input  logic [W*NREQ-1:0]  req_val,
  input  logic [DUR_W*NREQ-1:0] req_dur,
  output logic [NREQ-1:0]    gnt,
  output logic [NREQ-1:0]    done,
  output logic               x_inc,
  output logic               x_ld,
  output logic [W-1:0]       x_ld_val,
  output logic               y_inc,
  output logic               y_ld,
  output logic [W-1:0]       y_ld_val,
  output logic               busy,
  output state_t             dbg_state
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0] pick;
  logic [PW-1:0]   pick_idx;
  logic            pick_any;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   gidx_q, gidx_d;
  logic            tgt_q, tgt_d;
  ovr_op_t         op_q, op_d;
  logic [W-1:0]    val_q, val_d;
  logic [DUR_W-1:0] rem_q, rem_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic            x_inc_q, x_inc_d, x_ld_q, x_ld_d;
  logic            y_inc_q, y_inc_d, y_ld_q, y_ld_d;
  logic [W-1:0]    x_ld_val_q, x_ld_val_d, y_ld_val_q, y_ld_val_d;

  // Request fields of the current pick, muxed with constant indices.
  logic             sel_tgt;
  logic [1:0]       sel_op;
  logic [W-1:0]     sel_val;
  logic [DUR_W-1:0] sel_dur;

  // Override being driven in the next cycle.
  logic             ov_en, ov_first, ov_tgt;
  ovr_op_t          ov_op;
  logic [W-1:0]     ov_val;
  logic             t_inc, t_ld;
  logic [W-1:0]     t_val;
  logic [PW-1:0]    ptr_next;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req      (req),
    .ptr      (ptr_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .any      (pick_any)
  );

  always_comb begin
    sel_tgt = 1'b0;
    sel_op  = 2'b00;
    sel_val = '0;
    sel_dur = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == PW'(i)) begin
        sel_tgt = req_tgt[i];
        sel_op  = req_op[2*i +: 2];
        sel_val = req_val[W*i +: W];
        sel_dur = req_dur[DUR_W*i +: DUR_W];
      end
    end
  end

  assign ptr_next = (gidx_q == PW'(NREQ-1)) ? '0 : gidx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    gidx_d   = gidx_q;
    tgt_d    = tgt_q;
    op_d     = op_q;
    val_d    = val_q;
    rem_d    = rem_q;
    gnt_d    = '0;
    done_d   = '0;
    ov_en    = 1'b0;
    ov_first = 1'b0;
    ov_tgt   = tgt_q;
    ov_op    = op_q;
    ov_val   = val_q;
    case (state_q)
      S_IDLE: begin
        if (pick_any) begin
          state_d  = S_ACTIVE;
          gidx_d   = pick_idx;
          tgt_d    = sel_tgt;
          op_d     = ovr_op_t'(sel_op);
          val_d    = sel_val;
          rem_d    = sel_dur;
          gnt_d    = pick;
          ov_en    = 1'b1;
          ov_first = 1'b1;
          ov_tgt   = sel_tgt;
          ov_op    = ovr_op_t'(sel_op);
          ov_val   = sel_val;
        end
      end
      S_ACTIVE: begin
        // A dropped request aborts silently but still moves the pointer on.
        if (!(|(req & gnt_q))) begin
          state_d = S_IDLE;
          ptr_d   = ptr_next;
        end else if (rem_q == '0) begin
          state_d = S_DONE;
          done_d  = gnt_q;
          ptr_d   = ptr_next;
        end else begin
          rem_d = rem_q - 1'b1;
          gnt_d = gnt_q;
          ov_en = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Per-op effect on the targeted counter; inc and ld are never both set.
  always_comb begin
    t_inc = 1'b0;
    t_ld  = 1'b0;
    t_val = '0;
    case (ov_op)
      OP_CLEAR: t_ld = 1'b1;
      OP_LOAD: begin
        t_ld  = ov_first;
        t_val = ov_first ? ov_val : '0;
      end
      default: t_inc = 1'b0;
    endcase
  end

  always_comb begin
    x_inc_d    = 1'b1;
    x_ld_d     = 1'b0;
    x_ld_val_d = '0;
    y_inc_d    = 1'b1;
    y_ld_d     = 1'b0;
    y_ld_val_d = '0;
    if (ov_en && ov_tgt == TGT_X) begin
      x_inc_d    = t_inc;
      x_ld_d     = t_ld;
      x_ld_val_d = t_val;
    end
    if (ov_en && ov_tgt == TGT_Y) begin
      y_inc_d    = t_inc;
      y_ld_d     = t_ld;
      y_ld_val_d = t_val;
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      gidx_q     <= '0;
      tgt_q      <= TGT_X;
      op_q       <= OP_HOLD;
      val_q      <= '0;
      rem_q      <= '0;
      gnt_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
      x_inc_q    <= 1'b1;
      x_ld_q     <= 1'b0;
      x_ld_val_q <= '0;
      y_inc_q    <= 1'b1;
      y_ld_q     <= 1'b0;
      y_ld_val_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      gidx_q     <= gidx_d;
      tgt_q      <= tgt_d;
      op_q       <= op_d;
      val_q      <= val_d;
      rem_q      <= rem_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      x_inc_q    <= x_inc_d;
      x_ld_q     <= x_ld_d;
      x_ld_val_q <= x_ld_val_d;
      y_inc_q    <= y_inc_d;
      y_ld_q     <= y_ld_d;
      y_ld_val_q <= y_ld_val_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign x_inc     = x_inc_q;
  assign x_ld      = x_ld_q;
  assign x_ld_val  = x_ld_val_q;
  assign y_inc     = y_inc_q;
  assign y_ld      = y_ld_q;
  assign y_ld_val  = y_ld_val_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_cnt_override_arbiter.sv
// Directed bench for cnt_override_arbiter with a model x/y counter pair driven by its controls.
module tb_cnt_override_arbiter;
  import cnt_ovr_pkg::*;

  localparam int NREQ = 4;
  localparam int W = 4;
  localparam int DUR_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] req_tgt = '0;
  logic [2*NREQ-1:0] req_op = '0;
  logic [W*NREQ-1:0] req_val = '0;
  logic [DUR_W*NREQ-1:0] req_dur = '0;
  logic [NREQ-1:0] gnt, done;
  logic x_inc, x_ld, y_inc, y_ld, busy;
  logic [W-1:0] x_ld_val, y_ld_val;
  state_t dbg_state;

  logic [W-1:0] x_m = '0;
  logic [W-1:0] y_m = '0;

  int checks = 0;
  int errors = 0;

  cnt_override_arbiter #(.NREQ(NREQ), .W(W), .DUR_W(DUR_W)) dut (
    .clk(clk), .reset(reset), .req(req), .req_tgt(req_tgt), .req_op(req_op),
    .req_val(req_val), .req_dur(req_dur), .gnt(gnt), .done(done),
    .x_inc(x_inc), .x_ld(x_ld), .x_ld_val(x_ld_val),
    .y_inc(y_inc), .y_ld(y_ld), .y_ld_val(y_ld_val),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  // Counter datapath model: load wins over increment.
  always @(posedge clk) begin
    if (reset) begin
      x_m <= '0;
      y_m <= '0;
    end else begin
      x_m <= x_ld ? x_ld_val : (x_inc ? x_m + 1'b1 : x_m);
      y_m <= y_ld ? y_ld_val : (y_inc ? y_m + 1'b1 : y_m);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic tgt, input logic [1:0] op,
                         input logic [W-1:0] val, input logic [DUR_W-1:0] dur);
    req_tgt[i] = tgt;
    req_op[2*i +: 2] = op;
    req_val[W*i +: W] = val;
    req_dur[DUR_W*i +: DUR_W] = dur;
  endtask

  initial begin
    // 1: reset for 3 cycles, then free-run
    step(); step(); step();
    reset = 1'b0;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_x_inc", 32'(x_inc), 32'h1);
    chk("rst_y_inc", 32'(y_inc), 32'h1);
    chk("rst_x_ld", 32'(x_ld), 32'h0);
    chk("rst_x_m", 32'(x_m), 32'h0);
    step();
    chk("free_x_m1", 32'(x_m), 32'h1);
    step();
    chk("free_x_m2", 32'(x_m), 32'h2);
    chk("free_y_m2", 32'(y_m), 32'h2);

    // 2: req[1] hold x for 3 cycles
    set_req(1, TGT_X, 2'b00, 4'd0, 4'd2);
    req = 4'b0010;
    step();
    chk("hold_gnt_c1", 32'(gnt), 32'h2);
    chk("hold_x_inc", 32'(x_inc), 32'h0);
    chk("hold_y_inc", 32'(y_inc), 32'h1);
    chk("hold_busy", 32'(busy), 32'h1);
    chk("hold_x_m_c1", 32'(x_m), 32'h3);
    step();
    chk("hold_gnt_c2", 32'(gnt), 32'h2);
    step();
    chk("hold_gnt_c3", 32'(gnt), 32'h2);
    chk("hold_x_m_c3", 32'(x_m), 32'h3);
    step();
    chk("hold_done_gnt", 32'(gnt), 32'h0);
    chk("hold_done", 32'(done), 32'h2);
    chk("hold_done_x_inc", 32'(x_inc), 32'h1);
    chk("hold_done_x_m", 32'(x_m), 32'h3);
    req = 4'b0000;
    step();
    chk("hold_after_done", 32'(done), 32'h0);
    chk("hold_after_busy", 32'(busy), 32'h0);
    chk("hold_resume_x_m", 32'(x_m), 32'h4);
    chk("hold_y_m", 32'(y_m), 32'h7);

    // 3: req[0] load y = 9 for 4 cycles (pointer wraps from 2 to 0)
    set_req(0, TGT_Y, 2'b10, 4'd9, 4'd3);
    req = 4'b0001;
    step();
    chk("load_gnt", 32'(gnt), 32'h1);
    chk("load_y_ld_c1", 32'(y_ld), 32'h1);
    chk("load_y_val_c1", 32'(y_ld_val), 32'h9);
    chk("load_y_inc_c1", 32'(y_inc), 32'h0);
    chk("load_x_inc", 32'(x_inc), 32'h1);
    step();
    chk("load_y_ld_c2", 32'(y_ld), 32'h0);
    chk("load_y_inc_c2", 32'(y_inc), 32'h0);
    chk("load_y_m_c2", 32'(y_m), 32'h9);
    step();
    step();
    chk("load_gnt_c4", 32'(gnt), 32'h1);
    chk("load_y_m_c4", 32'(y_m), 32'h9);
    step();
    chk("load_done_gnt", 32'(gnt), 32'h0);
    chk("load_done", 32'(done), 32'h1);
    chk("load_done_y_m", 32'(y_m), 32'h9);
    req = 4'b0000;
    step();
    chk("load_resume_y_m", 32'(y_m), 32'ha);
    chk("load_after_busy", 32'(busy), 32'h0);

    // 4: all four request clear, dur 0; pointer restarted from reset
    reset = 1'b1;
    step(); step(); step();
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_req(i, i[0], 2'b01, 4'd0, 4'd0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
      if ((k % 2) == 0) begin
        chk("rr_x_ld", 32'(x_ld), 32'h1);
        chk("rr_x_ld_val", 32'(x_ld_val), 32'h0);
        chk("rr_y_inc", 32'(y_inc), 32'h1);
      end else begin
        chk("rr_y_ld", 32'(y_ld), 32'h1);
        chk("rr_x_inc", 32'(x_inc), 32'h1);
      end
      step();
      chk("rr_gap1_gnt", 32'(gnt), 32'h0);
      chk("rr_done", 32'(done), 32'(1 << (k % 4)));
      if (k == 0) chk("rr_clear_x_m", 32'(x_m), 32'h0);
      step();
      chk("rr_gap2_gnt", 32'(gnt), 32'h0);
      chk("rr_gap2_busy", 32'(busy), 32'h0);
      if (k == 4) req = 4'b0000;
    end

    // 5: req[2] clear x dur 7, aborted after 3 active cycles; pointer moves to 3
    set_req(2, TGT_X, 2'b01, 4'd0, 4'd7);
    req = 4'b0100;
    step();
    chk("abort_gnt_c1", 32'(gnt), 32'h4);
    chk("abort_x_ld", 32'(x_ld), 32'h1);
    step();
    step();
    chk("abort_gnt_c3", 32'(gnt), 32'h4);
    chk("abort_x_m", 32'(x_m), 32'h0);
    req = 4'b0000;
    step();
    chk("abort_gnt", 32'(gnt), 32'h0);
    chk("abort_no_done", 32'(done), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_x_ld_off", 32'(x_ld), 32'h0);
    chk("abort_x_inc", 32'(x_inc), 32'h1);
    set_req(0, TGT_X, 2'b00, 4'd0, 4'd0);
    set_req(1, TGT_X, 2'b00, 4'd0, 4'd0);
    set_req(3, TGT_Y, 2'b00, 4'd0, 4'd0);
    req = 4'b1011;
    step();
    chk("abort_next_gnt", 32'(gnt), 32'h8);
    chk("abort_next_y_inc", 32'(y_inc), 32'h0);
    step();
    chk("abort_next_done", 32'(done), 32'h8);
    req = 4'b0000;
    step();

    // 6: reset in the middle of a load override
    set_req(1, TGT_X, 2'b00, 4'd0, 4'd0);
    req = 4'b0010;
    step();
    chk("pre_rst_gnt1", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    step();
    set_req(3, TGT_X, 2'b10, 4'd5, 4'd5);
    req = 4'b1000;
    step();
    chk("mid_gnt", 32'(gnt), 32'h8);
    chk("mid_x_ld", 32'(x_ld), 32'h1);
    chk("mid_x_ld_val", 32'(x_ld_val), 32'h5);
    step();
    chk("mid_x_ld_c2", 32'(x_ld), 32'h0);
    chk("mid_x_inc_c2", 32'(x_inc), 32'h0);
    reset = 1'b1;
    step();
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_x_ld", 32'(x_ld), 32'h0);
    chk("midrst_x_inc", 32'(x_inc), 32'h1);
    chk("midrst_y_inc", 32'(y_inc), 32'h1);
    chk("midrst_x_ld_val", 32'(x_ld_val), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    chk("midrst_x_m", 32'(x_m), 32'h0);
    reset = 1'b0;
    set_req(2, TGT_Y, 2'b00, 4'd0, 4'd0);
    req = 4'b0110;
    step();
    chk("midrst_ptr_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    step();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
